// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control front-end:
// ALU opcodes, sequencer states and the error codes shown on the display.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam logic [15:0] RES_DIV0    = 16'hDEAD;
    localparam logic [15:0] RES_TIMEOUT = 16'hEEEE;

    // LED order is {DIV,MUL,SUB,ADD}, which matches the opcode values.
    function automatic logic [3:0] op_onehot(input op_e op);
        return 4'b0001 << op;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One raw board button: 2-FF synchronizer, stability-count debounce and a
// single-cycle pulse on each accepted press.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Any sample equal to the accepted level restarts the stability window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control front-end: conditions the buttons, holds the selected
// operation, latches operands and runs the start/done handshake to the ALU.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int OPW             = 8
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [15:0]      sw,
    input  logic             btnU,
    input  logic             btnD,
    input  logic             btnL,
    input  logic             btnR,
    input  logic             btnC,
    output logic             alu_start,
    output logic [1:0]       alu_op,
    output logic [OPW-1:0]   alu_a,
    output logic [OPW-1:0]   alu_b,
    input  logic             alu_done,
    input  logic [15:0]      alu_result,
    output logic [15:0]      result_q,
    output logic             result_valid,
    output logic             err_div0,
    output logic             err_timeout,
    output logic             busy,
    output logic [3:0]       op_led
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [4:0]     w_raw;
    logic [4:0]     w_press;
    state_e         r_state;
    state_e         w_next;
    op_e            r_sel;
    op_e            r_op;
    logic [OPW-1:0] r_a;
    logic [OPW-1:0] r_b;
    logic [15:0]    r_result;
    logic           r_err_div0;
    logic           r_err_tmo;
    logic [TW-1:0]  r_tmo_cnt;
    logic           w_div0;
    logic           w_expire;

    assign w_raw = {btnC, btnR, btnL, btnD, btnU};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (CLK100MHZ),
            .rst_n  (CPU_RESETN),
            .i_btn  (w_raw[g]),
            .o_press(w_press[g])
        );
    end

    assign w_div0   = (r_sel == OP_DIV) && (sw[2*OPW-1:OPW] == '0);
    // The counter value seen here is one behind the cycle count since ISSUE.
    assign w_expire = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_press[4]) w_next = ST_LATCH;
            ST_LATCH: w_next = w_div0 ? ST_DONE : ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (alu_done || w_expire) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Op presses are honoured only while idle; U > D > L > R on a tie.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_sel <= OP_ADD;
        end else if (r_state == ST_IDLE) begin
            if (w_press[0])      r_sel <= OP_ADD;
            else if (w_press[1]) r_sel <= OP_SUB;
            else if (w_press[2]) r_sel <= OP_MUL;
            else if (w_press[3]) r_sel <= OP_DIV;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
            r_result   <= '0;
            r_err_div0 <= 1'b0;
            r_err_tmo  <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            unique case (r_state)
                ST_LATCH: begin
                    r_a        <= sw[OPW-1:0];
                    r_b        <= sw[2*OPW-1:OPW];
                    r_op       <= r_sel;
                    r_err_tmo  <= 1'b0;
                    r_err_div0 <= w_div0;
                    if (w_div0) r_result <= RES_DIV0;
                end
                ST_ISSUE: r_tmo_cnt <= '0;
                ST_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (alu_done) begin
                        r_result <= alu_result;
                    end else if (w_expire) begin
                        r_result  <= RES_TIMEOUT;
                        r_err_tmo <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_start    = (r_state == ST_ISSUE);
    assign result_valid = (r_state == ST_DONE);
    assign busy         = (r_state != ST_IDLE);
    assign alu_op       = r_op;
    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign result_q     = r_result;
    assign err_div0     = r_err_div0;
    assign err_timeout  = r_err_tmo;
    assign op_led       = op_onehot(r_sel);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a short debounce window and a
// behavioural ALU whose latency is set per transaction.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic        btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnC = 1'b0;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic        alu_done;
    logic [15:0] alu_result = 16'h0000;
    logic [15:0] result_q;
    logic        result_valid, err_div0, err_timeout, busy;
    logic [3:0]  op_led;

    logic        model_done = 1'b0;
    logic        manual_done = 1'b0;
    int          alu_lat = 3;
    int          n_cmp = 0;
    int          n_fail = 0;

    assign alu_done = model_done | manual_done;

    calc_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64),
        .OPW            (8)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .sw          (sw),
        .btnU        (btnU),
        .btnD        (btnD),
        .btnL        (btnL),
        .btnR        (btnR),
        .btnC        (btnC),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .result_q    (result_q),
        .result_valid(result_valid),
        .err_div0    (err_div0),
        .err_timeout (err_timeout),
        .busy        (busy),
        .op_led      (op_led)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        case (op)
            2'd0:    return 16'(a) + 16'(b);
            2'd1:    return 16'(a) - 16'(b);
            2'd2:    return 16'(a) * 16'(b);
            default: return (b == 8'd0) ? 16'h0000 : {a % b, a / b};
        endcase
    endfunction

    // Behavioural ALU: samples the start pulse on the falling edge and raises
    // done alu_lat cycles later; alu_lat == 0 never answers.
    always begin
        logic [15:0] res;
        @(negedge clk);
        model_done = 1'b0;
        if (alu_start && alu_lat > 0) begin
            res = alu_model(alu_op, alu_a, alu_b);
            repeat (alu_lat - 1) @(negedge clk);
            alu_result = res;
            model_done = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int which);
        case (which)
            0: btnU = 1'b1;
            1: btnD = 1'b1;
            2: btnL = 1'b1;
            default: btnR = 1'b1;
        endcase
        repeat (10) @(negedge clk);
        {btnU, btnD, btnL, btnR} = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    // Presses compute and follows the transaction; n counts falling edges
    // after the press, so alu_start is expected at n == 8.
    task automatic do_compute(input string tag, input int lat, input bit poke,
                              output int starts, output int start_at, output int valid_at,
                              output logic [1:0] op_seen);
        int n = 0;
        alu_lat  = lat;
        starts   = 0;
        start_at = -1;
        valid_at = -1;
        op_seen  = 2'bxx;
        btnC = 1'b1;
        while (valid_at < 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 12) btnC = 1'b0;
            if (poke && start_at > 0 && n == start_at + 2) begin
                btnL = 1'b1;
                sw   = 16'hFFFF;
            end
            if (poke && start_at > 0 && n == start_at + 14) begin
                btnL = 1'b0;
                check({tag, "_a_hold"}, alu_a, 8'h0A);
                check({tag, "_b_hold"}, alu_b, 8'h03);
                check({tag, "_op_hold"}, op_led, 4'b0001);
            end
            if (alu_start) begin
                starts++;
                if (start_at < 0) begin
                    start_at = n;
                    op_seen  = alu_op;
                end
            end
            if (result_valid) valid_at = n;
        end
        btnC = 1'b0;
        check({tag, "_valid_seen"}, valid_at >= 0, 1'b1);
        @(negedge clk);
        check({tag, "_valid_pulse"}, result_valid, 1'b0);
        check({tag, "_busy_drop"}, busy, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int starts, start_at, valid_at, seen_valid, seen_busy;
        logic [1:0] op_seen;

        repeat (3) @(negedge clk);
        check("rst_op_led", op_led, 4'b0001);
        check("rst_busy", busy, 1'b0);
        check("rst_result", result_q, 16'h0000);
        check("rst_start", alu_start, 1'b0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_errs", {err_div0, err_timeout}, 2'b00);
        check("rst_operands", {alu_op, alu_a, alu_b}, 18'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // ADD, SUB, MUL, DIV with A=0x0A, B=0x03, ALU latency 3.
        sw = 16'h030A;
        press(0);
        check("add_led", op_led, 4'b0001);
        do_compute("add", 3, 1'b0, starts, start_at, valid_at, op_seen);
        check("add_starts", starts, 1);
        check("add_start_lat", start_at, 8);
        check("add_op", op_seen, 2'd0);
        check("add_done_lat", valid_at - start_at, 3);
        check("add_res", result_q, 16'h000D);

        press(1);
        check("sub_led", op_led, 4'b0010);
        do_compute("sub", 3, 1'b0, starts, start_at, valid_at, op_seen);
        check("sub_start_lat", start_at, 8);
        check("sub_op", op_seen, 2'd1);
        check("sub_res", result_q, 16'h0007);

        press(2);
        check("mul_led", op_led, 4'b0100);
        do_compute("mul", 3, 1'b0, starts, start_at, valid_at, op_seen);
        check("mul_start_lat", start_at, 8);
        check("mul_op", op_seen, 2'd2);
        check("mul_res", result_q, 16'h001E);

        press(3);
        check("div_led", op_led, 4'b1000);
        do_compute("div", 3, 1'b0, starts, start_at, valid_at, op_seen);
        check("div_start_lat", start_at, 8);
        check("div_op", op_seen, 2'd3);
        check("div_res", result_q, 16'h0103);
        check("div_err", {err_div0, err_timeout}, 2'b00);

        // Divide by zero: no ALU start, error code shown, valid still pulses.
        sw = 16'h000A;
        do_compute("div0", 3, 1'b0, starts, start_at, valid_at, op_seen);
        check("div0_starts", starts, 0);
        check("div0_valid_lat", valid_at, 8);
        check("div0_res", result_q, 16'hDEAD);
        check("div0_flag", err_div0, 1'b1);

        sw = 16'h030A;
        press(0);
        do_compute("clr", 3, 1'b0, starts, start_at, valid_at, op_seen);
        check("clr_flag", err_div0, 1'b0);
        check("clr_res", result_q, 16'h000D);

        // ALU never answers.
        do_compute("tmo", 0, 1'b0, starts, start_at, valid_at, op_seen);
        check("tmo_starts", starts, 1);
        check("tmo_lat", valid_at - start_at, 64);
        check("tmo_res", result_q, 16'hEEEE);
        check("tmo_flag", err_timeout, 1'b1);

        // Short glitch on btnU must not change the selection.
        press(1);
        btnU = 1'b1;
        repeat (2) @(negedge clk);
        btnU = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_led", op_led, 4'b0010);

        // Simultaneous U and L: ADD wins.
        btnU = 1'b1;
        btnL = 1'b1;
        repeat (10) @(negedge clk);
        {btnU, btnL} = 2'b00;
        repeat (10) @(negedge clk);
        check("tie_led", op_led, 4'b0001);

        // Op press and switch change while waiting on the ALU are ignored.
        do_compute("poke", 30, 1'b1, starts, start_at, valid_at, op_seen);
        check("poke_res", result_q, 16'h000D);
        check("poke_done_lat", valid_at - start_at, 30);
        check("poke_err_clr", err_timeout, 1'b0);
        check("poke_led", op_led, 4'b0001);
        sw = 16'h030A;

        // Reset pulse during WAIT abandons the transaction.
        press(2);
        alu_lat = 0;
        btnC = 1'b1;
        starts = 0;
        for (int i = 0; i < 20 && starts == 0; i++) begin
            @(negedge clk);
            if (alu_start) starts = 1;
        end
        btnC = 1'b0;
        check("rstw_started", starts, 1);
        repeat (3) @(negedge clk);
        check("rstw_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstw_busy", busy, 1'b0);
        check("rstw_led", op_led, 4'b0001);
        check("rstw_res", result_q, 16'h0000);
        check("rstw_operands", {alu_op, alu_a, alu_b}, 18'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        seen_valid = 0;
        seen_busy  = 0;
        for (int i = 0; i < 10; i++) begin
            if (result_valid) seen_valid++;
            if (busy) seen_busy++;
            @(negedge clk);
        end
        check("rstw_no_valid", seen_valid, 0);
        check("rstw_idle", seen_busy, 0);
        check("rstw_res_after", result_q, 16'h0000);
        check("rstw_errs", {err_div0, err_timeout}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Control front-end for the calculator datapath. It conditions the raw board buttons, holds the selected operation, and latches operands from the switches on a compute request. It then drives a start/done handshake to the multi-cycle ALU and publishes the result, or an error code, to the display/LED logic. It sits between the board I/O and the ALU, and replaces the ad-hoc button decoding in the top level.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz)
TIMEOUT_CYCLES, 64, maximum cycles to wait for alu_done after alu_start
OPW, 8, operand width (A = sw[7:0], B = sw[15:8])

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  reset, asynchronous assert, active-low
sw  in  16  operand switches, B in [15:8], A in [7:0]
btnU  in  1  raw button, select ADD
btnD  in  1  raw button, select SUB
btnL  in  1  raw button, select MUL
btnR  in  1  raw button, select DIV
btnC  in  1  raw button, compute
alu_start  out  1  one-cycle start pulse to the ALU
alu_op  out  2  opcode to the ALU: ADD=0, SUB=1, MUL=2, DIV=3
alu_a  out  OPW  latched operand A
alu_b  out  OPW  latched operand B
alu_done  in  1  ALU completion pulse
alu_result  in  16  ALU result, sampled on alu_done
result_q  out  16  displayed value
result_valid  out  1  one-cycle pulse when result_q updates
err_div0  out  1  sticky flag: divide by zero
err_timeout  out  1  sticky flag: ALU did not respond
busy  out  1  high from LATCH through DONE
op_led  out  4  one-hot selected op, {DIV,MUL,SUB,ADD}

Behaviour:
- Reset (CPU_RESETN=0, asynchronous):
  - state IDLE; all outputs 0, except op_led=4'b0001 (ADD selected).
  - Debounce counters and synchronizers cleared.
  - Reset asserted mid-operation abandons the transaction; a later alu_done is ignored.
- Button conditioning, per button:
  - 2-FF synchronizer, then a stability counter.
  - Accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A rising edge of the accepted level gives a one-cycle press pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Op select:
  - Accepted only in IDLE; presses while busy are dropped.
  - Presses in the same cycle resolve with priority U > D > L > R.
  - Selection persists until the next press or reset.
- FSM states: IDLE, LATCH, ISSUE, WAIT, DONE.
  - IDLE: on a compute press, go to LATCH.
  - LATCH: capture alu_a=sw[7:0], alu_b=sw[15:8], alu_op=selected op; clear err_div0 and err_timeout.
    - If op=DIV and sw[15:8]==0: result_q=16'hDEAD, err_div0=1, go to DONE. No alu_start is issued.
    - Otherwise go to ISSUE.
  - ISSUE: alu_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - WAIT: the counter increments each cycle.
    - On alu_done: result_q=alu_result, go to DONE.
    - When the counter reaches TIMEOUT_CYCLES-1 without alu_done: result_q=16'hEEEE, err_timeout=1, go to DONE.
    - alu_done in the expiry cycle: done wins, no timeout.
  - DONE: result_valid=1 for one cycle; go to IDLE.
- Latency: compute press pulse at cycle N gives alu_start at N+2. alu_done at cycle M gives result_valid at M+1.
- Operands stay stable from LATCH until the next LATCH; sw changes while busy have no effect.
- Compute presses while busy are dropped, not queued.
- alu_done outside WAIT is ignored.
- result_q, err_div0 and err_timeout hold until the next LATCH or reset.

Decomposition:
- Package calc_pkg:
  - Opcode constants: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - State encoding.
  - Constants RES_DIV0=16'hDEAD and RES_TIMEOUT=16'hEEEE.
- Sub-module btn_conditioner (synchronizer, debounce counter, rising-edge pulse; parameter DEBOUNCE_CYCLES), instantiated five times.
- Bench uses DEBOUNCE_CYCLES=4 and a behavioural ALU model with configurable latency.

Test Plan:
- Reset, then A=0x0A, B=0x03, press U, press C; ALU latency 3 -> one alu_start with alu_op=0; result_q=0x000D, result_valid one cycle; op_led=0001.
- Same operands with D, L and R in turn -> results 0x0007, 0x001E, 0x0103 (remainder in [15:8], quotient in [7:0]); alu_start at press+2 each time.
- B=0x00, press R, press C -> no alu_start; result_q=0xDEAD; err_div0=1; result_valid pulses; flag clears on the next valid compute.
- ALU model never asserts done -> err_timeout=1 and result_q=0xEEEE exactly TIMEOUT_CYCLES cycles after alu_start; busy then drops.
- btnU glitch of 2 cycles -> op unchanged. U and L pressed together -> ADD selected. Press L during WAIT -> ignored; sw change during WAIT -> alu_a and alu_b unchanged.
- CPU_RESETN pulsed low during WAIT, with alu_done arriving 2 cycles after release -> outputs at reset values, state IDLE, no result_valid.
